// File: rtl/btb_pkg.sv
// Shared BTB geometry constants, controller state encoding and the
// resolution-event record carried through the update queue.
package btb_pkg;

   localparam int unsigned BTB_SETS    = 8;
   localparam int unsigned BTB_WAYS    = 2;
   localparam int unsigned BTB_INDEX_W = 3;
   localparam int unsigned BTB_TAG_W   = 27;
   localparam int unsigned BTB_SET_W   = 128;
   localparam int unsigned EVT_W       = 65;

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_IDLE  = 2'd1,
      ST_FLUSH = 2'd2
   } btb_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] target;
      logic        mispredicted;
   } btb_evt_t;

endpackage

// File: rtl/btb_evt_fifo.sv
// Resolution-event queue: DEPTH x {pc, target, mispredicted}, synchronous
// flush, plus a look-ahead full flag so the owner can register its ready.
module btb_evt_fifo
   import btb_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             wr_en,
   input  logic [EVT_W-1:0] wr_data,
   input  logic             rd_en,
   output logic [EVT_W-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic             full_nx
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W + 1)'(DEPTH);

   logic [EVT_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W:0]   count;
   logic [PTR_W:0]   count_nx;
   logic             do_wr;
   logic             do_rd;

   assign do_wr   = wr_en && !full && !flush;
   assign do_rd   = rd_en && !empty && !flush;
   assign full    = (count == DEPTH_CNT);
   assign empty   = (count == '0);
   assign rd_data = mem[rd_ptr];

   always_comb begin
      count_nx = count;
      if (flush)
         count_nx = '0;
      else if (do_wr && !do_rd)
         count_nx = count + 1'b1;
      else if (do_rd && !do_wr)
         count_nx = count - 1'b1;
   end

   assign full_nx = (count_nx == DEPTH_CNT);

   // Pointers are PTR_W wide, so DEPTH being a power of two gives the wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_nx;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_wr)
               wr_ptr <= wr_ptr + 1'b1;
            if (do_rd)
               rd_ptr <= rd_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/btb_ctrl.sv
// BTB sequencer: queues EX resolution events, drains one per cycle to the BTB
// update port, runs the set-clear walk after reset/flush and gates prediction.
module btb_ctrl
   import btb_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 2,
   parameter int unsigned NUM_SETS   = BTB_SETS,
   parameter int unsigned INDEX_W    = BTB_INDEX_W,
   parameter int unsigned CNT_W      = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               res_valid,
   input  logic [31:0]        res_pc,
   input  logic [31:0]        res_target,
   input  logic               res_mispredicted,
   output logic               res_ready,
   input  logic               flush_req,
   output logic               btb_update,
   output logic [31:0]        btb_update_pc,
   output logic [31:0]        btb_update_target,
   output logic               btb_mispredicted,
   output logic               btb_clear,
   output logic [INDEX_W-1:0] btb_clear_index,
   output logic               pred_enable,
   output logic               busy,
   output logic [CNT_W-1:0]   mispredict_cnt
);

   localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_SETS - 1);

   btb_state_t         state;
   logic [INDEX_W-1:0] clear_idx;

   logic               fifo_wr_en;
   logic               fifo_rd_en;
   logic [EVT_W-1:0]   fifo_wr_data;
   logic [EVT_W-1:0]   fifo_rd_data;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_full_nx;
   btb_evt_t           head;

   assign fifo_wr_data = {res_pc, res_target, res_mispredicted};
   assign fifo_wr_en   = res_valid && res_ready && !fifo_full && !flush_req;
   assign fifo_rd_en   = (state == ST_IDLE) && !fifo_empty && !flush_req;
   assign head         = fifo_rd_data;

   btb_evt_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_evt_fifo (
      .clk     (clk),
      .rst     (rst),
      .flush   (flush_req),
      .wr_en   (fifo_wr_en),
      .wr_data (fifo_wr_data),
      .rd_en   (fifo_rd_en),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .full_nx (fifo_full_nx)
   );

   // Outputs describe the state held during the edge that produced them, so the
   // reset cycle shows no clear and pred_enable trails the last clear by one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state             <= ST_INIT;
         clear_idx         <= '0;
         btb_update        <= 1'b0;
         btb_update_pc     <= '0;
         btb_update_target <= '0;
         btb_mispredicted  <= 1'b0;
         btb_clear         <= 1'b0;
         btb_clear_index   <= '0;
         pred_enable       <= 1'b0;
         busy              <= 1'b1;
         res_ready         <= 1'b0;
         mispredict_cnt    <= '0;
      end else begin
         btb_update <= 1'b0;
         btb_clear  <= 1'b0;
         if (flush_req) begin
            state       <= ST_FLUSH;
            clear_idx   <= '0;
            pred_enable <= 1'b0;
            busy        <= 1'b1;
            res_ready   <= 1'b0;
         end else begin
            case (state)
               ST_INIT, ST_FLUSH: begin
                  btb_clear       <= 1'b1;
                  btb_clear_index <= clear_idx;
                  pred_enable     <= 1'b0;
                  busy            <= 1'b1;
                  res_ready       <= 1'b0;
                  if (clear_idx == LAST_IDX) begin
                     state     <= ST_IDLE;
                     clear_idx <= '0;
                  end else begin
                     clear_idx <= clear_idx + 1'b1;
                  end
               end
               ST_IDLE: begin
                  pred_enable <= 1'b1;
                  busy        <= 1'b0;
                  res_ready   <= !fifo_full_nx;
                  if (!fifo_empty) begin
                     btb_update        <= 1'b1;
                     btb_update_pc     <= head.pc;
                     btb_update_target <= head.target;
                     btb_mispredicted  <= head.mispredicted;
                     if (head.mispredicted && (mispredict_cnt != '1))
                        mispredict_cnt <= mispredict_cnt + 1'b1;
                  end
               end
               default: begin
                  state     <= ST_INIT;
                  clear_idx <= '0;
               end
            endcase
         end
      end
   end

   a_update_clear_excl: assert property (@(posedge clk) disable iff (rst)
      !(btb_update && btb_clear));

endmodule
